// File: rtl/cmac_pkg.sv
// Shared types and constants for the CMAC TX gating logic.
package cmac_pkg;

    typedef enum logic [1:0] {
        GATE_DOWN    = 2'd0,
        GATE_HOLDOFF = 2'd1,
        GATE_UP      = 2'd2,
        GATE_ABORT   = 2'd3
    } gate_state_e;

    localparam int unsigned CMAC_FREQ_HZ    = 32'd322265625;
    localparam int unsigned DEFAULT_HOLDOFF = 32'd1024;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterized saturating incrementer with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment unless already pinned at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cmac_tx_gate.sv
// Gates the user TX stream into the CMAC on PCS alignment: drops whole frames
// while the link is down and closes a frame cut by link loss with an abort beat.
module cmac_tx_gate
    import cmac_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF,
    parameter int CNT_WIDTH      = 32,
    parameter int SYNC_STAGES    = 4
) (
    input  logic                    tx_clk,
    input  logic                    tx_reset,
    input  logic                    stat_rx_aligned,
    input  logic [DATA_WIDTH-1:0]   axis_in_tdata,
    input  logic [DATA_WIDTH/8-1:0] axis_in_tkeep,
    input  logic                    axis_in_tlast,
    input  logic                    axis_in_tvalid,
    output logic                    axis_in_tready,
    output logic [DATA_WIDTH-1:0]   axis_out_tdata,
    output logic [DATA_WIDTH/8-1:0] axis_out_tkeep,
    output logic                    axis_out_tlast,
    output logic                    axis_out_tuser,
    output logic                    axis_out_tvalid,
    input  logic                    axis_out_tready,
    output logic                    link_up,
    output logic [CNT_WIDTH-1:0]    pkts_passed,
    output logic [CNT_WIDTH-1:0]    pkts_dropped,
    output logic [CNT_WIDTH-1:0]    pkts_aborted
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int HO_WIDTH   = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HO_WIDTH-1:0]   HO_LOAD  = HO_WIDTH'(HOLDOFF_CYCLES);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   aligned_s;
    gate_state_e            state_q, state_d;
    logic [HO_WIDTH-1:0]    ho_q, ho_d;
    logic                   in_mid_q, in_mid_d;
    logic                   abort_tail_q, abort_tail_d;
    logic                   in_fire_s;
    logic                   inc_passed_s, inc_dropped_s, inc_aborted_s;

    // Alignment synchronizer into tx_clk.
    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], stat_rx_aligned};
        end
    end

    assign aligned_s = sync_q[SYNC_STAGES-1];
    assign in_fire_s = axis_in_tvalid & axis_in_tready;
    assign link_up   = (state_q == GATE_UP);

    // Upstream ready and downstream beat selection per state.
    always_comb begin
        axis_in_tready  = 1'b1;
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tuser  = 1'b0;
        axis_out_tvalid = 1'b0;
        case (state_q)
            GATE_UP: begin
                axis_in_tready  = axis_out_tready;
                axis_out_tdata  = axis_in_tdata;
                axis_out_tkeep  = axis_in_tkeep;
                axis_out_tlast  = axis_in_tlast;
                axis_out_tvalid = axis_in_tvalid;
            end
            GATE_ABORT: begin
                axis_in_tready  = 1'b0;
                axis_out_tkeep  = KEEP_ONE;
                axis_out_tlast  = 1'b1;
                axis_out_tuser  = 1'b1;
                axis_out_tvalid = 1'b1;
            end
            default: begin
                axis_in_tready  = 1'b1;
            end
        endcase
    end

    // Next state, holdoff count, frame tracking and counter strobes.
    always_comb begin
        state_d       = state_q;
        ho_d          = ho_q;
        abort_tail_d  = abort_tail_q;
        inc_passed_s  = 1'b0;
        inc_dropped_s = 1'b0;
        inc_aborted_s = 1'b0;
        if (in_fire_s) begin
            in_mid_d = ~axis_in_tlast;
        end else begin
            in_mid_d = in_mid_q;
        end
        case (state_q)
            GATE_DOWN, GATE_HOLDOFF: begin
                // The tail of an aborted frame was already counted as aborted.
                if (in_fire_s && axis_in_tlast) begin
                    if (abort_tail_q) begin
                        abort_tail_d = 1'b0;
                    end else begin
                        inc_dropped_s = 1'b1;
                    end
                end
                if (state_q == GATE_DOWN) begin
                    if (aligned_s) begin
                        ho_d    = HO_LOAD;
                        state_d = GATE_HOLDOFF;
                    end
                end else begin
                    if (ho_q != '0) begin
                        ho_d = ho_q - HO_WIDTH'(1);
                    end
                    if (!aligned_s) begin
                        state_d = GATE_DOWN;
                    end else if ((ho_q == '0) && !in_mid_q && !in_fire_s) begin
                        state_d = GATE_UP;
                    end
                end
            end
            GATE_UP: begin
                inc_passed_s = in_fire_s & axis_in_tlast;
                // Judge the frame position after this cycle's beat so a
                // completing tlast never triggers an abort.
                if (!aligned_s) begin
                    if (in_mid_d) begin
                        state_d      = GATE_ABORT;
                        abort_tail_d = 1'b1;
                    end else begin
                        state_d = GATE_DOWN;
                    end
                end
            end
            GATE_ABORT: begin
                if (axis_out_tready) begin
                    inc_aborted_s = 1'b1;
                    state_d       = GATE_DOWN;
                end
            end
            default: begin
                state_d = GATE_DOWN;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            state_q      <= GATE_DOWN;
            ho_q         <= '0;
            in_mid_q     <= 1'b0;
            abort_tail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ho_q         <= ho_d;
            in_mid_q     <= in_mid_d;
            abort_tail_q <= abort_tail_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_passed (
        .clk_i   (tx_clk),
        .clr_i   (tx_reset),
        .inc_i   (inc_passed_s),
        .count_o (pkts_passed)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_dropped (
        .clk_i   (tx_clk),
        .clr_i   (tx_reset),
        .inc_i   (inc_dropped_s),
        .count_o (pkts_dropped)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_aborted (
        .clk_i   (tx_clk),
        .clr_i   (tx_reset),
        .inc_i   (inc_aborted_s),
        .count_o (pkts_aborted)
    );

endmodule

// File: tb/tb_cmac_tx_gate.sv
// Directed, table-driven bench for cmac_tx_gate with small widths and holdoff.
module tb_cmac_tx_gate;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int HO = 16;
    localparam int CW = 4;
    localparam int SS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          aligned;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic          out_last;
    logic          out_user;
    logic          out_valid;
    logic          out_ready;
    logic          lu;
    logic [CW-1:0] n_passed, n_dropped, n_aborted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          vld;
        logic          rdy;
        logic          last;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          e_ovalid;
        logic          e_iready;
        logic [CW-1:0] e_passed;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    cmac_tx_gate #(
        .DATA_WIDTH     (DW),
        .HOLDOFF_CYCLES (HO),
        .CNT_WIDTH      (CW),
        .SYNC_STAGES    (SS)
    ) dut (
        .tx_clk          (clk),
        .tx_reset        (rst),
        .stat_rx_aligned (aligned),
        .axis_in_tdata   (in_data),
        .axis_in_tkeep   (in_keep),
        .axis_in_tlast   (in_last),
        .axis_in_tvalid  (in_valid),
        .axis_in_tready  (in_ready),
        .axis_out_tdata  (out_data),
        .axis_out_tkeep  (out_keep),
        .axis_out_tlast  (out_last),
        .axis_out_tuser  (out_user),
        .axis_out_tvalid (out_valid),
        .axis_out_tready (out_ready),
        .link_up         (lu),
        .pkts_passed     (n_passed),
        .pkts_dropped    (n_dropped),
        .pkts_aborted    (n_aborted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [DW-1:0] d, input logic [KW-1:0] k);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        in_keep  = k;
        #1;
    endtask

    task automatic wait_link(input logic exp, output int n);
        n = 0;
        while ((lu !== exp) && (n < 100)) begin
            tick();
            n++;
        end
        chk("wait_link", {63'd0, lu}, {63'd0, exp});
    endtask

    // Drive a whole frame with an always-ready sink; every beat is checked for
    // pass-through (pass=1) or for silent discard (pass=0).
    task automatic frame(input int beats, input logic [DW-1:0] base, input logic pass);
        for (int i = 0; i < beats; i++) begin
            drive(1'b1, (i == beats - 1), base + DW'(i), 4'hF);
            chk("frame_ovalid", {63'd0, out_valid}, {63'd0, pass});
            chk("frame_iready", {63'd0, in_ready}, 64'd1);
            if (pass) begin
                chk("frame_odata", {32'd0, out_data}, {32'd0, base + DW'(i)});
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 4'h0);
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic l, input logic [DW-1:0] d,
                                input logic [KW-1:0] k, input logic eo, input logic ei, input logic [CW-1:0] ep);
        vec_t x;
        x.vld = v; x.rdy = r; x.last = l; x.data = d; x.keep = k;
        x.e_ovalid = eo; x.e_iready = ei; x.e_passed = ep;
        return x;
    endfunction

    initial begin
        int n;
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'hA0000001, 4'hF, 1'b1, 1'b1, 4'd1);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'hB0000000, 4'hF, 1'b1, 1'b1, 4'd1);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'hB0000001, 4'hF, 1'b1, 1'b0, 4'd1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'hB0000001, 4'hF, 1'b1, 1'b1, 4'd1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 32'hB0000002, 4'h3, 1'b1, 1'b1, 4'd2);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'hC0000000, 4'hF, 1'b1, 1'b1, 4'd2);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'd2);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'hC0000001, 4'h1, 1'b1, 1'b1, 4'd3);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 32'hD0000000, 4'h7, 1'b1, 1'b0, 4'd3);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'hD0000000, 4'h7, 1'b1, 1'b1, 4'd4);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'hE0000000, 4'hF, 1'b1, 1'b1, 4'd4);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 32'hE0000001, 4'h8, 1'b1, 1'b1, 4'd5);

        rst = 1'b1; aligned = 1'b0; out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
        chk("rst_iready", {63'd0, in_ready}, 64'd1);
        chk("rst_link", {63'd0, lu}, 64'd0);
        chk("rst_passed", {60'd0, n_passed}, 64'd0);
        chk("rst_dropped", {60'd0, n_dropped}, 64'd0);

        // Dead link: three 4-beat frames are swallowed.
        for (int f = 0; f < 3; f++) frame(4, 32'h10000000 + DW'(f * 16), 1'b0);
        chk("down_dropped", {60'd0, n_dropped}, 64'd3);

        // Alignment up: holdoff plus synchronizer latency.
        aligned = 1'b1;
        n = 0;
        while (!lu && n < 100) begin
            tick();
            n++;
        end
        chk("holdoff_latency_in_range", {63'd0, (n >= HO + SS && n <= HO + SS + 2)}, 64'd1);

        // Pass-through table with backpressure and gaps.
        for (int i = 0; i < 13; i++) begin
            out_ready = vecs[i].rdy;
            drive(vecs[i].vld, vecs[i].last, vecs[i].data, vecs[i].keep);
            chk("vec_ovalid", {63'd0, out_valid}, {63'd0, vecs[i].e_ovalid});
            chk("vec_iready", {63'd0, in_ready}, {63'd0, vecs[i].e_iready});
            chk("vec_user", {63'd0, out_user}, 64'd0);
            if (vecs[i].vld) begin
                chk("vec_data", {32'd0, out_data}, {32'd0, vecs[i].data});
                chk("vec_keep", {60'd0, out_keep}, {60'd0, vecs[i].keep});
                chk("vec_last", {63'd0, out_last}, {63'd0, vecs[i].last});
            end
            tick();
            chk("vec_passed", {60'd0, n_passed}, {60'd0, vecs[i].e_passed});
        end
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        chk("up_passed", {60'd0, n_passed}, 64'd5);

        // Link down between frames, then holdoff expires mid-frame.
        aligned = 1'b0;
        wait_link(1'b0, n);
        aligned = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, DW'(i), 4'hF);
            tick();
        end
        chk("midflight_link", {63'd0, lu}, 64'd0);
        drive(1'b1, 1'b1, 32'h0000FFFF, 4'hF);
        chk("midflight_last_ovalid", {63'd0, out_valid}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        chk("midflight_hold", {63'd0, lu}, 64'd0);
        tick();
        chk("midflight_up", {63'd0, lu}, 64'd1);
        chk("midflight_dropped", {60'd0, n_dropped}, 64'd4);
        frame(2, 32'h20000000, 1'b1);
        chk("midflight_passed", {60'd0, n_passed}, 64'd6);

        // Alignment lost after beat 2 of 6 with the sink stalled.
        frame(0, 32'd0, 1'b1);
        drive(1'b1, 1'b0, 32'h30000001, 4'hF); tick();
        drive(1'b1, 1'b0, 32'h30000002, 4'hF); tick();
        aligned = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h30000003, 4'hF);
        n = 0;
        while (!out_user && n < 20) begin
            tick();
            n++;
        end
        chk("abort_seen", {63'd0, out_user}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) out_ready = 1'b1;
            #1;
            chk("abort_valid", {63'd0, out_valid}, 64'd1);
            chk("abort_last", {63'd0, out_last}, 64'd1);
            chk("abort_user", {63'd0, out_user}, 64'd1);
            chk("abort_keep", {60'd0, out_keep}, 64'd1);
            chk("abort_data", {32'd0, out_data}, 64'd0);
            chk("abort_iready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        chk("abort_count", {60'd0, n_aborted}, 64'd1);
        frame(4, 32'h30000003, 1'b0);
        chk("abort_tail_not_dropped", {60'd0, n_dropped}, 64'd4);
        chk("abort_passed_same", {60'd0, n_passed}, 64'd6);

        // Alignment falls exactly on the tlast transfer cycle.
        aligned = 1'b1;
        wait_link(1'b1, n);
        drive(1'b1, 1'b0, 32'h40000000, 4'hF); tick();
        drive(1'b1, 1'b0, 32'h40000001, 4'hF); tick();
        aligned = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        repeat (SS) tick();
        drive(1'b1, 1'b1, 32'h40000002, 4'hF);
        chk("edge_last_ovalid", {63'd0, out_valid}, 64'd1);
        chk("edge_last_user", {63'd0, out_user}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        chk("edge_state_down", {63'd0, lu}, 64'd0);
        chk("edge_no_abort", {63'd0, out_valid}, 64'd0);
        chk("edge_passed", {60'd0, n_passed}, 64'd7);
        chk("edge_aborted", {60'd0, n_aborted}, 64'd1);

        // Reset while the abort beat is pending.
        aligned = 1'b1;
        wait_link(1'b1, n);
        drive(1'b1, 1'b0, 32'h50000000, 4'hF); tick();
        aligned = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 4'h0);
        n = 0;
        while (!out_user && n < 20) begin
            tick();
            n++;
        end
        chk("rst_abort_seen", {63'd0, out_user}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rsta_passed", {60'd0, n_passed}, 64'd0);
        chk("rsta_dropped", {60'd0, n_dropped}, 64'd0);
        chk("rsta_aborted", {60'd0, n_aborted}, 64'd0);
        chk("rsta_ovalid", {63'd0, out_valid}, 64'd0);
        chk("rsta_link", {63'd0, lu}, 64'd0);

        // Saturation: 17 frames into a 4-bit counter.
        aligned = 1'b1;
        wait_link(1'b1, n);
        for (int f = 0; f < 17; f++) begin
            frame(1, 32'h60000000 + DW'(f), 1'b1);
            if (f == 14) chk("sat_reach", {60'd0, n_passed}, 64'd15);
        end
        chk("sat_hold", {60'd0, n_passed}, 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
